// File: rtl/video_timing_analyzer.sv
// Measures line/frame geometry of a sync/blank stream, tracks lock on stable
// geometry and reconstructs the active-area pixel/line position.
module video_timing_analyzer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_pix,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       hbl,
  input  logic       vbl,
  output logic [8:0] h_total,
  output logic [8:0] v_total,
  output logic [8:0] hs_width,
  output logic [8:0] vs_width,
  output logic [8:0] h_active,
  output logic [8:0] v_active,
  output logic [8:0] hc,
  output logic [8:0] vc,
  output logic       locked,
  output logic       frame_tick,
  output logic [1:0] lock_state
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lock_state_e;

  localparam logic [8:0] MAX = 9'h1FF;

  lock_state_e state_q, state_d;
  logic hs_q, vs_q, hbl_q, vbl_q;
  logic hs_rise, hs_fall, vs_rise, vs_fall, hbl_fall, vbl_fall;
  logic [8:0] px_q, ln_q, hsw_q, hac_q, vsw_q, vac_q;
  logic [8:0] cht_q, chsw_q, cha_q, cvsw_q, ref_h_q, ref_v_q;
  logic [8:0] ht_q, vt_q, hsw_out_q, vsw_out_q, ha_out_q, va_out_q, hc_q, vc_q;
  logic tmo_q, tmo_d, ft_q, locked_q;
  logic [8:0] ln_eff, h_cand, v_cand, hsw_cand, ha_cand, va_cand;
  logic px_sat, ln_sat, timeout, match, ref_ld, out_ld;

  // Edges only exist on enabled cycles; history updates only then too.
  assign hs_rise  = clk_pix &  hsync & ~hs_q;
  assign hs_fall  = clk_pix & ~hsync &  hs_q;
  assign vs_rise  = clk_pix &  vsync & ~vs_q;
  assign vs_fall  = clk_pix & ~vsync &  vs_q;
  assign hbl_fall = clk_pix & ~hbl   &  hbl_q;
  assign vbl_fall = clk_pix & ~vbl   &  vbl_q;

  assign px_sat  = clk_pix & ~hs_rise & (px_q == MAX);
  assign ln_sat  = hs_rise & (ln_q == MAX);
  assign timeout = px_sat | ln_sat;

  // A coincident hsync rise is counted into the frame that vsync closes.
  assign ln_eff   = (hs_rise && ln_q != MAX) ? ln_q + 9'd1 : ln_q;
  assign v_cand   = ln_eff - 9'd1;
  assign h_cand   = hs_rise ? px_q : cht_q;
  assign ha_cand  = hs_rise ? hac_q : cha_q;
  assign hsw_cand = hs_fall ? hsw_q : chsw_q;
  assign va_cand  = (hs_rise && !vbl && vac_q != MAX) ? vac_q + 9'd1 : vac_q;
  assign match    = (h_cand == ref_h_q) && (v_cand == ref_v_q);

  always_comb begin
    state_d = state_q;
    ref_ld  = 1'b0;
    out_ld  = 1'b0;
    tmo_d   = tmo_q;
    if (vs_rise) tmo_d = 1'b0;
    else if (timeout) tmo_d = 1'b1;
    if (timeout) begin
      state_d = SEARCH;
    end else if (vs_rise) begin
      if (tmo_q) begin
        state_d = SEARCH;
      end else begin
        case (state_q)
          SEARCH: begin
            ref_ld  = 1'b1;
            state_d = VERIFY;
          end
          VERIFY: begin
            if (match) begin
              state_d = LOCKED;
              out_ld  = 1'b1;
            end else begin
              ref_ld = 1'b1;
            end
          end
          LOCKED: begin
            if (match) out_ld = 1'b1;
            else state_d = SEARCH;
          end
          default: state_d = SEARCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEARCH;
      {hs_q, vs_q, hbl_q, vbl_q} <= 4'b0;
      {tmo_q, ft_q, locked_q} <= 3'b0;
      px_q <= '0; ln_q <= '0; hsw_q <= '0; hac_q <= '0; vsw_q <= '0; vac_q <= '0;
      cht_q <= '0; chsw_q <= '0; cha_q <= '0; cvsw_q <= '0;
      ref_h_q <= '0; ref_v_q <= '0;
      ht_q <= '0; vt_q <= '0; hsw_out_q <= '0; vsw_out_q <= '0;
      ha_out_q <= '0; va_out_q <= '0; hc_q <= '0; vc_q <= '0;
    end else begin
      state_q  <= state_d;
      locked_q <= (state_d == LOCKED);
      ft_q     <= vs_rise;
      tmo_q    <= tmo_d;
      if (clk_pix) begin
        {hs_q, vs_q, hbl_q, vbl_q} <= {hsync, vsync, hbl, vbl};
        if (hs_rise) px_q <= '0;
        else if (px_q != MAX) px_q <= px_q + 9'd1;
        if (hs_rise) hsw_q <= 9'd1;
        else if (hsync && hsw_q != MAX) hsw_q <= hsw_q + 9'd1;
        if (hs_fall) chsw_q <= hsw_q;
        if (hs_rise) begin
          cht_q <= px_q;
          cha_q <= hac_q;
          hac_q <= {8'd0, ~hbl};
        end else if (!hbl && hac_q != MAX) begin
          hac_q <= hac_q + 9'd1;
        end
        if (vs_rise) ln_q <= '0;
        else if (hs_rise) ln_q <= ln_eff;
        if (vs_rise) vsw_q <= {8'd0, hs_rise};
        else if (hs_rise && vsync && vsw_q != MAX) vsw_q <= vsw_q + 9'd1;
        if (vs_fall) cvsw_q <= vsw_q;
        vac_q <= vs_rise ? 9'd0 : va_cand;
        if (hbl_fall) hc_q <= '0;
        else if (!hbl && hc_q != MAX) hc_q <= hc_q + 9'd1;
        if (vbl_fall) vc_q <= '0;
        else if (hbl_fall && !vbl && vc_q != MAX) vc_q <= vc_q + 9'd1;
      end
      if (ref_ld) begin
        ref_h_q <= h_cand;
        ref_v_q <= v_cand;
      end
      if (out_ld) begin
        ht_q      <= h_cand;
        vt_q      <= v_cand;
        hsw_out_q <= hsw_cand;
        vsw_out_q <= cvsw_q;
        ha_out_q  <= ha_cand;
        va_out_q  <= va_cand;
      end
    end
  end

  assign h_total    = ht_q;
  assign v_total    = vt_q;
  assign hs_width   = hsw_out_q;
  assign vs_width   = vsw_out_q;
  assign h_active   = ha_out_q;
  assign v_active   = va_out_q;
  assign hc         = hc_q;
  assign vc         = vc_q;
  assign locked     = locked_q;
  assign frame_tick = ft_q;
  assign lock_state = state_q;

endmodule

// File: tb/tb_video_timing_analyzer.sv
// Directed bench: table of scaled geometries checked for lock and measured
// values, plus sequences for geometry change, sync loss, position, gating, reset.
module tb_video_timing_analyzer;

  logic       clk = 1'b0;
  logic       reset_n, clk_pix, hsync, vsync, hbl, vbl;
  logic [8:0] h_total, v_total, hs_width, vs_width, h_active, v_active, hc, vc;
  logic       locked, frame_tick;
  logic [1:0] lock_state;

  video_timing_analyzer dut (
    .clk(clk), .reset_n(reset_n), .clk_pix(clk_pix),
    .hsync(hsync), .vsync(vsync), .hbl(hbl), .vbl(vbl),
    .h_total(h_total), .v_total(v_total), .hs_width(hs_width), .vs_width(vs_width),
    .h_active(h_active), .v_active(v_active), .hc(hc), .vc(vc),
    .locked(locked), .frame_tick(frame_tick), .lock_state(lock_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ll; int hsw; int hbs; int hbw; int nl; int vsw; int vbs; int vbw;
    logic [8:0] e_ht; logic [8:0] e_vt; logic [8:0] e_hsw;
    logic [8:0] e_vsw; logic [8:0] e_ha; logic [8:0] e_va;
  } vec_t;

  vec_t vecs[5];
  vec_t g;
  int   cur_x, cur_y;
  bit   force_hs_low, half_rate;
  int   n_cmp = 0, n_bad = 0, cyc = 0;
  logic [8:0] exp_q[$];

  always @(posedge clk) begin
    cyc++;
    if (cyc > 90000) begin
      $display("FAIL watchdog: cycles %0d, limit 90000", cyc);
      $fatal(1, "cycle budget exceeded");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_px();
    int pos;
    pos     = cur_y * g.ll + cur_x;
    hsync   = (cur_x < g.hsw) && !force_hs_low;
    vsync   = cur_y < g.vsw;
    hbl     = !(cur_x >= g.hbs && cur_x < g.hbs + g.hbw);
    vbl     = !(pos >= g.vbs * g.ll + g.hbs && pos < (g.vbs + g.vbw) * g.ll + g.hbs);
    clk_pix = 1'b1;
  endtask

  task automatic px_en();
    apply_px();
    tick();
    cur_x++;
    if (cur_x == g.ll) begin
      cur_x = 0;
      cur_y++;
      if (cur_y == g.nl) cur_y = 0;
    end
  endtask

  // Disabled cycle with scrambled syncs: must be invisible to the analyzer.
  task automatic px_dis();
    clk_pix = 1'b0;
    hsync   = 1'($urandom_range(0, 1));
    vsync   = 1'($urandom_range(0, 1));
    hbl     = 1'($urandom_range(0, 1));
    vbl     = 1'($urandom_range(0, 1));
    tick();
  endtask

  task automatic drive_px(input int n);
    for (int i = 0; i < n; i++) begin
      px_en();
      if (half_rate) px_dis();
    end
  endtask

  task automatic to_frame_end();
    int pos;
    pos = cur_y * g.ll + cur_x;
    if (pos != 0) drive_px(g.ll * g.nl - pos);
  endtask

  task automatic next_vs();
    to_frame_end();
    drive_px(1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    {clk_pix, hsync, vsync, hbl, vbl} = 5'b0;
    force_hs_low = 1'b0;
    half_rate    = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    cur_x = 0;
    cur_y = 0;
    tick();
  endtask

  task automatic check_outs(input vec_t v, input string tag);
    exp_q.push_back(v.e_ht);  exp_q.push_back(v.e_vt);
    exp_q.push_back(v.e_hsw); exp_q.push_back(v.e_vsw);
    exp_q.push_back(v.e_ha);  exp_q.push_back(v.e_va);
    check({tag, "_h_total"},  h_total,  exp_q.pop_front());
    check({tag, "_v_total"},  v_total,  exp_q.pop_front());
    check({tag, "_hs_width"}, hs_width, exp_q.pop_front());
    check({tag, "_vs_width"}, vs_width, exp_q.pop_front());
    check({tag, "_h_active"}, h_active, exp_q.pop_front());
    check({tag, "_v_active"}, v_active, exp_q.pop_front());
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_h_total"}, h_total, 9'd0);
    check({tag, "_v_total"}, v_total, 9'd0);
    check({tag, "_hs_width"}, hs_width, 9'd0);
    check({tag, "_vs_width"}, vs_width, 9'd0);
    check({tag, "_h_active"}, h_active, 9'd0);
    check({tag, "_v_active"}, v_active, 9'd0);
    check({tag, "_hc"}, hc, 9'd0);
    check({tag, "_vc"}, vc, 9'd0);
    check({tag, "_locked"}, {8'd0, locked}, 9'd0);
    check({tag, "_frame_tick"}, {8'd0, frame_tick}, 9'd0);
  endtask

  initial begin
    int drop;
    //          ll   hsw hbs hbw  nl  vsw vbs vbw   ht   vt   hsw  vsw  ha   va
    vecs[0] = '{48,  4,  8,  32,  20, 2,  3,  14,  47,  19,  4,   2,   32,  14};
    vecs[1] = '{64,  8,  12, 40,  24, 3,  4,  16,  63,  23,  8,   3,   40,  16};
    vecs[2] = '{40,  1,  2,  37,  12, 1,  1,  10,  39,  11,  1,   1,   37,  10};
    vecs[3] = '{512, 100,120,300, 6,  1,  1,  3,   511, 5,   100, 1,   300, 3};
    vecs[4] = '{8,   1,  2,  4,   300,8,  20, 224, 7,   299, 1,   8,   4,   224};

    g = vecs[0];
    reset_n = 1'b0;
    {clk_pix, hsync, vsync, hbl, vbl} = 5'b0;
    force_hs_low = 1'b0;
    half_rate    = 1'b0;
    repeat (2) tick();
    check_all_zero("reset");
    check("reset_lock_state", {7'd0, lock_state}, 9'd0);

    // Lock is expected exactly at the third vsync rise after reset.
    for (int i = 0; i < 5; i++) begin
      g = vecs[i];
      do_reset();
      next_vs();
      next_vs();
      check($sformatf("v%0d_locked_pre", i), {8'd0, locked}, 9'd0);
      next_vs();
      check($sformatf("v%0d_locked", i), {8'd0, locked}, 9'd1);
      check($sformatf("v%0d_tick_hi", i), {8'd0, frame_tick}, 9'd1);
      check_outs(vecs[i], $sformatf("v%0d", i));
      drive_px(1);
      check($sformatf("v%0d_tick_lo", i), {8'd0, frame_tick}, 9'd0);
    end

    // Geometry change: 48 -> 49 pixels per line from a frame boundary.
    g = vecs[0];
    do_reset();
    repeat (3) next_vs();
    check("geo_locked", {8'd0, locked}, 9'd1);
    to_frame_end();
    g.ll = 49;
    next_vs();
    check("geo_still_locked", {8'd0, locked}, 9'd1);
    next_vs();
    check("geo_drop", {8'd0, locked}, 9'd0);
    check("geo_hold_h_total", h_total, 9'd47);
    next_vs();
    check("geo_verify", {8'd0, locked}, 9'd0);
    next_vs();
    check("geo_relock", {8'd0, locked}, 9'd1);
    check("geo_h_total", h_total, 9'd48);
    check("geo_v_total", v_total, 9'd19);

    // Loss of hsync while locked.
    g = vecs[1];
    do_reset();
    repeat (3) next_vs();
    check("loss_locked", {8'd0, locked}, 9'd1);
    force_hs_low = 1'b1;
    drop = 0;
    for (int i = 0; i < 600; i++) begin
      drive_px(1);
      if (drop == 0 && !locked) drop = i + 1;
    end
    n_cmp++;
    if (drop == 0 || drop > 512) begin
      n_bad++;
      $display("FAIL loss_drop: locked dropped after %0d enables, required 1..512", drop);
    end
    check_outs(vecs[1], "loss_hold");
    force_hs_low = 1'b0;

    // Position reconstruction: active area lines 4..19, pixels 12..51.
    g = vecs[1];
    do_reset();
    drive_px(4 * 64 + 12 + 1);
    check("pos_first_hc", hc, 9'd0);
    check("pos_first_vc", vc, 9'd0);
    drive_px(39);
    check("pos_line_end_hc", hc, 9'd39);
    drive_px(1);
    check("pos_blank_hold_hc", hc, 9'd39);
    drive_px(19 * 64 + 51 - (4 * 64 + 53) + 1);
    check("pos_last_hc", hc, 9'd39);
    check("pos_last_vc", vc, 9'd15);
    drive_px(20 * 64 + 12 - (19 * 64 + 52) + 1);
    check("pos_after_hc", hc, 9'd0);
    check("pos_after_vc", vc, 9'd15);

    // Half-rate enable with scrambled inputs on disabled cycles.
    g = vecs[0];
    do_reset();
    half_rate = 1'b1;
    next_vs();
    next_vs();
    check("half_locked_pre", {8'd0, locked}, 9'd0);
    to_frame_end();
    px_en();
    check("half_tick_hi", {8'd0, frame_tick}, 9'd1);
    check("half_locked", {8'd0, locked}, 9'd1);
    px_dis();
    check("half_tick_lo", {8'd0, frame_tick}, 9'd0);
    check_outs(vecs[0], "half");
    half_rate = 1'b0;

    // Asynchronous reset mid-line while locked, then relock.
    g = vecs[0];
    do_reset();
    repeat (3) next_vs();
    check("rst_locked", {8'd0, locked}, 9'd1);
    drive_px(5 * 48 + 20 - 1);
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    repeat (2) tick();
    reset_n = 1'b1;
    next_vs();
    check("rst_rise1", {8'd0, locked}, 9'd0);
    next_vs();
    check("rst_rise2", {8'd0, locked}, 9'd0);
    next_vs();
    check("rst_rise3", {8'd0, locked}, 9'd1);
    check_outs(vecs[0], "rst_relock");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
